// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared state encoding, default sizing and helpers for the
// burst clock-divider scheduler (div_sched, div_sched_arb).
package div_sched_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned CW_DEF   = 26;
  localparam int unsigned BW_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_sched_arb.sv
// div_sched_arb: combinational requester arbiter producing a one-hot winner.
// Default: round-robin search starting at ptr_i.
// DIV_SCHED_FIXED_PRIO_EN: fixed priority, lowest index wins, ptr_i ignored.
module div_sched_arb
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned PW   = ptr_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_o
);

`ifdef DIV_SCHED_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Lowest-index active request wins.
  always_comb begin
    logic found;
    found = 1'b0;
    win_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_i[i]) begin
        win_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`else

  // Scan requesters from ptr_i upward with wrap-around; first active one wins.
  always_comb begin
    logic             found;
    logic [31:0]      pos;
    logic [PW-1:0]    idx;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    win_o = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      idx = PW'(pos);
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/div_sched.sv
// div_sched: grants one requester at a time a burst of divided-clock periods
// on freq_out (half-period = lim+1 clocks, first half low), then pulses done.
// Arbitration lives in div_sched_arb; define DIV_SCHED_FIXED_PRIO_EN for
// fixed-priority instead of round-robin.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned CW   = CW_DEF,
  parameter int unsigned BW   = BW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] lim_flat,
  input  logic [BW-1:0]      burst_len,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               freq_out,
  output logic [NREQ-1:0]    done
);

  localparam int unsigned PW = ptr_width(NREQ);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [NREQ-1:0] done_q,  done_d;
  logic            freq_q,  freq_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [BW-1:0]   ecnt_q,  ecnt_d;
  logic [CW-1:0]   lim_q,   lim_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [PW-1:0]   widx_q,  widx_d;
  logic [PW-1:0]   ptr_q,   ptr_d;

  logic [NREQ-1:0] arb_win;
  logic [PW-1:0]   arb_idx;
  logic [CW-1:0]   lim_sel;
  logic [PW-1:0]   ptr_next;
  logic            req_held;
  logic [BW-1:0]   ecnt_inc;

  div_sched_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (arb_win)
  );

  // Encode the one-hot winner and pick out its divider limit.
  always_comb begin
    arb_idx = '0;
    lim_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_win[i]) begin
        arb_idx = PW'(i);
        lim_sel = lim_flat[i*CW +: CW];
      end
    end
  end

  // Round-robin pointer moves to the requester after the current winner.
  always_comb begin
    logic [31:0] nxt;
    nxt = 32'(widx_q) + 32'd1;
    if (nxt >= NREQ) begin
      nxt = '0;
    end
    ptr_next = PW'(nxt);
  end

  assign req_held = req[widx_q];
  assign ecnt_inc = ecnt_q + BW'(1);

  // Next-state and datapath control for the IDLE/LOAD/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    lim_d   = lim_q;
    burst_d = burst_q;
    widx_d  = widx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = arb_win;
          widx_d  = arb_idx;
          lim_d   = lim_sel;
          burst_d = (burst_len == '0) ? BW'(1) : burst_len;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        ecnt_d  = '0;
        freq_d  = 1'b0;
        state_d = req_held ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (!req_held) begin
          // Withdrawn request: finish without a done pulse.
          freq_d  = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == lim_q) begin
          cnt_d  = '0;
          freq_d = ~freq_q;
          if (freq_q) begin
            ecnt_d = ecnt_inc;
            if (ecnt_inc == burst_q) begin
              freq_d  = 1'b0;
              done_d  = gnt_q;
              state_d = ST_DONE;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = ptr_next;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      freq_q  <= 1'b0;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      lim_q   <= '0;
      burst_q <= '0;
      widx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      lim_q   <= lim_d;
      burst_q <= burst_d;
      widx_q  <= widx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign freq_out = freq_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
